alt_eyemon_dprio2avmm: RTL and testbench

//  DPRIO responder: accepts alt_dprio-style wren/rden requests from an upstream gasket and answers with busy/data.

---
 rtl/alt_eyemon_dprio2avmm.sv | 103 ++++++++++
 tb/tb_alt_eyemon_dprio2avmm.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alt_eyemon_dprio2avmm.sv
// DPRIO responder turning wren/rden requests into single AVMM master transfers.
// Optional CMD-state timeout: define ALT_EYEMON_DPRIO2AVMM_TIMEOUT_EN.
module alt_eyemon_dprio2avmm #(
  parameter int DPRIO_ADDR_WIDTH = 16,
  parameter int DPRIO_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter logic [DPRIO_DATA_WIDTH-1:0] TIMEOUT_RDATA = 16'hFFFF
) (
  input  logic                        i_avmm_clk,
  input  logic                        i_resetn,
  input  logic                        i_dprio_wren,
  input  logic                        i_dprio_rden,
  input  logic [DPRIO_ADDR_WIDTH-1:0] i_dprio_addr,
  input  logic [DPRIO_DATA_WIDTH-1:0] i_dprio_data,
  output logic                        o_dprio_busy,
  output logic [DPRIO_DATA_WIDTH-1:0] o_dprio_out,
  output logic [DPRIO_ADDR_WIDTH-1:0] o_avmm_address,
  output logic                        o_avmm_read,
  output logic                        o_avmm_write,
  output logic [DPRIO_DATA_WIDTH-1:0] o_avmm_writedata,
  input  logic [DPRIO_DATA_WIDTH-1:0] i_avmm_readdata,
  input  logic                        i_avmm_waitrequest,
  output logic                        o_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RELEASE
  } state_t;

  state_t state;

`ifdef ALT_EYEMON_DPRIO2AVMM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state            <= IDLE;
      o_dprio_busy     <= 1'b0;
      o_dprio_out      <= '0;
      o_avmm_address   <= '0;
      o_avmm_read      <= 1'b0;
      o_avmm_write     <= 1'b0;
      o_avmm_writedata <= '0;
`ifdef ALT_EYEMON_DPRIO2AVMM_TIMEOUT_EN
      o_timeout        <= 1'b0;
      tmo_cnt          <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          // write wins when both strobes arrive together
          if (i_dprio_wren || i_dprio_rden) begin
            o_avmm_address   <= i_dprio_addr;
            o_avmm_writedata <= i_dprio_data;
            o_avmm_write     <= i_dprio_wren;
            o_avmm_read      <= ~i_dprio_wren;
            o_dprio_busy     <= 1'b1;
            state            <= CMD;
`ifdef ALT_EYEMON_DPRIO2AVMM_TIMEOUT_EN
            tmo_cnt          <= '0;
`endif
          end
        end
        CMD: begin
          if (!i_avmm_waitrequest) begin
            if (o_avmm_read)
              o_dprio_out <= i_avmm_readdata;
            o_avmm_read  <= 1'b0;
            o_avmm_write <= 1'b0;
            o_dprio_busy <= 1'b0;
            state        <= RELEASE;
          end
`ifdef ALT_EYEMON_DPRIO2AVMM_TIMEOUT_EN
          else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            if (o_avmm_read)
              o_dprio_out <= TIMEOUT_RDATA;
            o_avmm_read  <= 1'b0;
            o_avmm_write <= 1'b0;
            o_dprio_busy <= 1'b0;
            o_timeout    <= 1'b1;
            state        <= RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          // a strobe still held from the last request must not re-fire
          if (!i_dprio_wren && !i_dprio_rden)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alt_eyemon_dprio2avmm.sv
// Bench for alt_eyemon_dprio2avmm: scoreboard of expected AVMM transfers.
// Timeout scenario runs when ALT_EYEMON_DPRIO2AVMM_TIMEOUT_EN is defined.
module tb_alt_eyemon_dprio2avmm;

  logic        clk;
  logic        rst_n;
  logic        wren;
  logic        rden;
  logic [15:0] addr;
  logic [15:0] wdat;
  logic        busy;
  logic [15:0] dout;
  logic [15:0] av_addr;
  logic        av_rd;
  logic        av_wr;
  logic [15:0] av_wdata;
  logic [15:0] av_rdata;
  logic        av_wait;
  logic        tmo;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t exp_q[$];
  txn_t e;
  int   n_pass;
  int   n_total;
  int   n_rd;
  int   n_wr;

  alt_eyemon_dprio2avmm #(
    .DPRIO_ADDR_WIDTH(16),
    .DPRIO_DATA_WIDTH(16),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_RDATA(16'hFFFF)
  ) dut (
    .i_avmm_clk        (clk),
    .i_resetn          (rst_n),
    .i_dprio_wren      (wren),
    .i_dprio_rden      (rden),
    .i_dprio_addr      (addr),
    .i_dprio_data      (wdat),
    .o_dprio_busy      (busy),
    .o_dprio_out       (dout),
    .o_avmm_address    (av_addr),
    .o_avmm_read       (av_rd),
    .o_avmm_write      (av_wr),
    .o_avmm_writedata  (av_wdata),
    .i_avmm_readdata   (av_rdata),
    .i_avmm_waitrequest(av_wait),
    .o_timeout         (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // completed AVMM transfers are matched against the expected queue
  always @(negedge clk) begin
    if (rst_n && (av_rd || av_wr) && !av_wait) begin
      if (av_rd) n_rd++;
      if (av_wr) n_wr++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL xfer_unexpected: rd=%b wr=%b addr=%h, none expected",
                 av_rd, av_wr, av_addr);
      end else begin
        e = exp_q.pop_front();
        if ({av_rd, av_wr, av_addr, (av_wr ? av_wdata : 16'h0)} !==
            {~e.wr, e.wr, e.addr, (e.wr ? e.data : 16'h0)})
          $display("FAIL xfer: rd=%b wr=%b addr=%h wd=%h, want wr=%b addr=%h wd=%h",
                   av_rd, av_wr, av_addr, av_wdata, e.wr, e.addr, e.data);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wren = 0; rden = 0; addr = '0; wdat = '0;
    av_rdata = '0; av_wait = 1'b0;
    repeat (3) tick();
    n_total++;
    if ({busy, av_rd, av_wr, av_addr, av_wdata, dout, tmo} !== 52'h0)
      $display("FAIL reset: busy=%b rd=%b wr=%b addr=%h wd=%h out=%h tmo=%b, want all 0",
               busy, av_rd, av_wr, av_addr, av_wdata, dout, tmo);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_zero_wait();
    av_wait = 1'b0;
    wren = 1; addr = 16'h0123; wdat = 16'hBEEF;
    exp_q.push_back('{1'b1, 16'h0123, 16'hBEEF});
    tick();
    wren = 0;
    n_total++;
    if ({av_wr, av_rd, busy, av_addr, av_wdata} !== {3'b101, 16'h0123, 16'hBEEF})
      $display("FAIL wr_issue: wr=%b rd=%b busy=%b addr=%h wd=%h, want 1 0 1 0123 BEEF",
               av_wr, av_rd, busy, av_addr, av_wdata);
    else n_pass++;
    tick();
    n_total++;
    if ({av_wr, busy} !== 2'b00)
      $display("FAIL wr_done: wr=%b busy=%b, want 0 0", av_wr, busy);
    else n_pass++;
    n_total++;
    if (dout !== 16'h0000)
      $display("FAIL wr_out: out=%h, want 0000", dout);
    else n_pass++;
    tick();
  endtask

  task automatic test_read_wait();
    int bcyc;
    av_wait = 1'b1; av_rdata = 16'h5A5A;
    rden = 1; addr = 16'h0040;
    exp_q.push_back('{1'b0, 16'h0040, 16'h0});
    tick();
    rden = 0;
    bcyc = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy && av_rd) bcyc++;
      if (i < 3) tick();
    end
    av_wait = 1'b0;
    tick();
    n_total++;
    if (bcyc !== 4)
      $display("FAIL rd_busy_len: cycles=%0d, want 4", bcyc);
    else n_pass++;
    n_total++;
    if ({busy, av_rd, dout} !== {2'b00, 16'h5A5A})
      $display("FAIL rd_done: busy=%b rd=%b out=%h, want 0 0 5A5A", busy, av_rd, dout);
    else n_pass++;
    tick();
  endtask

  task automatic test_held_strobe();
    int rd0;
    int wr0;
    rd0 = n_rd;
    av_wait = 1'b0; av_rdata = 16'h1234;
    rden = 1; addr = 16'h0200;
    exp_q.push_back('{1'b0, 16'h0200, 16'h0});
    repeat (6) tick();
    n_total++;
    if ((n_rd - rd0) !== 1 || busy !== 1'b0)
      $display("FAIL held_reads: reads=%0d busy=%b, want 1 0", n_rd - rd0, busy);
    else n_pass++;
    n_total++;
    if (dout !== 16'h1234)
      $display("FAIL held_out: out=%h, want 1234", dout);
    else n_pass++;
    rden = 0;
    tick();
    wr0 = n_wr;
    wren = 1; addr = 16'h0300; wdat = 16'hCAFE;
    exp_q.push_back('{1'b1, 16'h0300, 16'hCAFE});
    tick();
    wren = 0;
    tick();
    n_total++;
    if ((n_wr - wr0) !== 1 || (n_rd - rd0) !== 1)
      $display("FAIL held_after: writes=%0d reads=%0d, want 1 1",
               n_wr - wr0, n_rd - rd0);
    else n_pass++;
    tick();
  endtask

  task automatic test_both_strobes();
    int rd0;
    rd0 = n_rd;
    av_wait = 1'b0; av_rdata = 16'h9999;
    wren = 1; rden = 1; addr = 16'h0007; wdat = 16'h7777;
    exp_q.push_back('{1'b1, 16'h0007, 16'h7777});
    tick();
    wren = 0; rden = 0;
    n_total++;
    if ({av_wr, av_rd, av_addr} !== {2'b10, 16'h0007})
      $display("FAIL both_issue: wr=%b rd=%b addr=%h, want 1 0 0007",
               av_wr, av_rd, av_addr);
    else n_pass++;
    tick();
    n_total++;
    if ({busy, dout} !== {1'b0, 16'h1234} || n_rd !== rd0)
      $display("FAIL both_done: busy=%b out=%h reads=%0d, want 0 1234 0",
               busy, dout, n_rd - rd0);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    av_wait = 1'b1;
    rden = 1; addr = 16'h0AAA;
    tick();
    rden = 0;
    tick();
    n_total++;
    if ({av_rd, busy} !== 2'b11)
      $display("FAIL mid_cmd: rd=%b busy=%b, want 1 1", av_rd, busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({av_rd, av_wr, busy, dout, av_addr} !== 35'h0)
      $display("FAIL mid_reset: rd=%b wr=%b busy=%b out=%h addr=%h, want all 0",
               av_rd, av_wr, busy, dout, av_addr);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    av_wait = 1'b0;
    tick();
    wren = 1; addr = 16'h0055; wdat = 16'hA5A5;
    exp_q.push_back('{1'b1, 16'h0055, 16'hA5A5});
    tick();
    wren = 0;
    n_total++;
    if ({av_wr, busy, av_addr, av_wdata} !== {2'b11, 16'h0055, 16'hA5A5})
      $display("FAIL post_reset_wr: wr=%b busy=%b addr=%h wd=%h, want 1 1 0055 A5A5",
               av_wr, busy, av_addr, av_wdata);
    else n_pass++;
    tick();
    n_total++;
    if ({av_wr, busy} !== 2'b00)
      $display("FAIL post_reset_done: wr=%b busy=%b, want 0 0", av_wr, busy);
    else n_pass++;
    tick();
  endtask

`ifdef ALT_EYEMON_DPRIO2AVMM_TIMEOUT_EN
  task automatic test_timeout();
    int scyc;
    av_wait = 1'b1;
    rden = 1; addr = 16'h0100;
    tick();
    rden = 0;
    scyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!av_rd) break;
      scyc++;
      tick();
    end
    n_total++;
    if (scyc !== 8)
      $display("FAIL tmo_len: strobe cycles=%0d, want 8", scyc);
    else n_pass++;
    n_total++;
    if ({busy, dout, tmo} !== {1'b0, 16'hFFFF, 1'b1})
      $display("FAIL tmo_rd: busy=%b out=%h tmo=%b, want 0 FFFF 1", busy, dout, tmo);
    else n_pass++;
    av_wait = 1'b0;
    tick();
    wren = 1; addr = 16'h0101; wdat = 16'h0F0F;
    exp_q.push_back('{1'b1, 16'h0101, 16'h0F0F});
    tick();
    wren = 0;
    repeat (2) tick();
    n_total++;
    if ({busy, tmo} !== 2'b01)
      $display("FAIL tmo_sticky: busy=%b tmo=%b, want 0 1", busy, tmo);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass = 0; n_total = 0; n_rd = 0; n_wr = 0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_held_strobe();
    test_both_strobes();
    test_reset_mid();
`ifdef ALT_EYEMON_DPRIO2AVMM_TIMEOUT_EN
    test_timeout();
`else
    n_total++;
    if (tmo !== 1'b0)
      $display("FAIL tmo_tied: tmo=%b, want 0", tmo);
    else n_pass++;
`endif
    repeat (2) tick();
    n_total++;
    if (exp_q.size() !== 0)
      $display("FAIL scoreboard_left: pending=%0d, want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
